// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - blanked time-multiplexed digit scan for shared-bus 7-segment displays
module display_scan_controller #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 2400,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digit_values,
    output logic [3:0]                    hex_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [3:0]              hex_q, hex_d;
    logic                    frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        frame_d = 1'b0;
        if (!enable) begin
            // Dropping enable truncates the current dwell without a frame pulse.
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    snap_d  = digit_values;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DWELL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            // Re-latching only at the wrap keeps a frame free of tearing.
                            idx_d   = '0;
                            snap_d  = digit_values;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so they change on the same edge as the state.
    always_comb begin
        hex_d = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_d[k] = ~((state_d == ST_DWELL) && (idx_d == IDX_W'(k)));
            if (idx_d == IDX_W'(k)) begin
                hex_d = snap_d[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            anode_q <= '1;
            hex_q   <= 4'h0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            anode_q <= anode_d;
            hex_q   <= hex_d;
            frame_q <= frame_d;
        end
    end

    assign hex_out    = hex_q;
    assign anode_n    = anode_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_q;

endmodule
